// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_t   : EX operand source select (register file, MEM result, WB result)
//   slot_t      : one scoreboard stage (EX, MEM or WB) worth of instruction info
//   slot_writes : true when a slot will write architectural register r
//   pick_fwd    : forwarding source for one EX operand, MEM before WB
// Register indices are carried at RD_W_MAX bits; narrower index widths are
// zero-extended by the top level, so XLEN_RD must not exceed RD_W_MAX.
package pipe_hazard_pkg;

  localparam int unsigned RD_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rs1;
    logic [RD_W_MAX-1:0] rs2;
    logic                has_rs1;
    logic                has_rs2;
    logic [RD_W_MAX-1:0] rd;
    logic                has_rd;
    logic                reg_write;
    logic                mem_read;
  } slot_t;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic slot_writes(slot_t s, logic [RD_W_MAX-1:0] r);
    return s.valid && s.reg_write && s.has_rd && (s.rd == r) && (r != '0);
  endfunction

  function automatic fwd_sel_t pick_fwd(logic use_src, logic [RD_W_MAX-1:0] r,
                                        slot_t mem_s, slot_t wb_s);
    if (!use_src)                return FWD_RF;
    else if (slot_writes(mem_s, r)) return FWD_MEM;
    else if (slot_writes(wb_s, r))  return FWD_WB;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctl_slot.sv
// hazard_slot: one scoreboard stage register with synchronous clear.
//   clk    : clock
//   clr_i  : synchronous clear (slot becomes invalid, all fields zero)
//   slot_i : next contents
//   slot_o : registered contents
module hazard_slot
  import pipe_hazard_pkg::*;
(
  input  logic  clk,
  input  logic  clr_i,
  input  slot_t slot_i,
  output slot_t slot_o
);

  slot_t slot_q;

  always_ff @(posedge clk) begin
    if (clr_i) slot_q <= '0;
    else       slot_q <= slot_i;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: load-use / RAW hazard detection, forwarding select and
// stall accounting for a 5-stage in-order pipeline.
// Optional feature macro: PIPE_HAZARD_FWD_EN
//   defined   : EX operands forwarded from MEM/WB; only load-use stalls.
//   undefined : no forwarding; any pending write to an ID source stalls.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   id_valid                   : decode holds a real instruction
//   id_rs1/id_rs2/id_rd        : decode register indices
//   id_has_rs1/_rs2/_rd        : operand-present flags
//   id_reg_write, id_mem_read  : decode control bits
//   ex_flush                   : taken branch/jump resolved in EX
//   stall_if_id                : hold PC and IF/ID
//   bubble_id_ex               : inject zero control into ID/EX
//   flush_if_id                : squash IF/ID
//   fwd_a, fwd_b               : EX operand source (00 RF, 01 MEM, 10 WB)
//   stall_cnt                  : saturating count of stall cycles
module pipe_hazard_ctl
  import pipe_hazard_pkg::*;
#(
  parameter int XLEN_RD = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN_RD-1:0] id_rs1,
  input  logic [XLEN_RD-1:0] id_rs2,
  input  logic               id_has_rs1,
  input  logic               id_has_rs2,
  input  logic               id_has_rd,
  input  logic [XLEN_RD-1:0] id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               ex_flush,
  output logic               stall_if_id,
  output logic               bubble_id_ex,
  output logic               flush_if_id,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_cnt
);

  slot_t id_slot, ex_d, ex_q, mem_q, wb_q;
  logic  hazard;
  fwd_sel_t fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.rs1       = RD_W_MAX'(id_rs1);
    id_slot.rs2       = RD_W_MAX'(id_rs2);
    id_slot.has_rs1   = id_has_rs1;
    id_slot.has_rs2   = id_has_rs2;
    id_slot.rd        = RD_W_MAX'(id_rd);
    id_slot.has_rd    = id_has_rd;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
  end

`ifdef PIPE_HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard = id_valid && ex_q.mem_read &&
             ((id_has_rs1 && slot_writes(ex_q, id_slot.rs1)) ||
              (id_has_rs2 && slot_writes(ex_q, id_slot.rs2)));
    fwd_a_sel = pick_fwd(ex_q.valid && ex_q.has_rs1, ex_q.rs1, mem_q, wb_q);
    fwd_b_sel = pick_fwd(ex_q.valid && ex_q.has_rs2, ex_q.rs2, mem_q, wb_q);
  end
`else
  // Without bypassing, the consumer waits until no older instruction in
  // flight still has to write its source (at most three cycles).
  always_comb begin
    hazard = id_valid &&
             ((id_has_rs1 && (slot_writes(ex_q, id_slot.rs1) ||
                              slot_writes(mem_q, id_slot.rs1) ||
                              slot_writes(wb_q, id_slot.rs1))) ||
              (id_has_rs2 && (slot_writes(ex_q, id_slot.rs2) ||
                              slot_writes(mem_q, id_slot.rs2) ||
                              slot_writes(wb_q, id_slot.rs2))));
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
  end
`endif

  // A taken branch squashes the decode instruction, so any stall is moot.
  assign stall_if_id  = hazard && !ex_flush;
  assign bubble_id_ex = hazard || ex_flush;
  assign flush_if_id  = ex_flush;
  assign fwd_a        = fwd_a_sel;
  assign fwd_b        = fwd_b_sel;

  assign ex_d = (id_valid && !bubble_id_ex) ? id_slot : '0;

  hazard_slot u_ex  (.clk(clk), .clr_i(rst), .slot_i(ex_d),  .slot_o(ex_q));
  hazard_slot u_mem (.clk(clk), .clr_i(rst), .slot_i(ex_q),  .slot_o(mem_q));
  hazard_slot u_wb  (.clk(clk), .clr_i(rst), .slot_i(mem_q), .slot_o(wb_q));

  assign stall_cnt_d = (stall_if_id && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

  // Not every slot field is consulted in every build.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

endmodule
